ysyx_24100006_axi_arbiter: RTL and testbench

Two-master to one-master AXI4 arbiter sitting directly upstream of the crossbar. It accepts instruction fetches from the IFU (read-only) and loads/stores from the LSU (read and write). It grants the single downstream AXI master port to one of them for a whole transaction and forwards it to the crossbar. It also produces the byte-lane offset (`m_addr_suffix`) that the crossbar uses to align sub-word read data.

---
 rtl/ysyx_24100006_axi_arbiter_pkg.sv | 15 +
 rtl/ysyx_24100006_axi_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_24100006_axi_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100006_axi_arbiter_pkg.sv
// Shared AXI arbiter definitions: grant states and response codes.
package ysyx_24100006_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFU_RD = 2'd1,
        ST_LSU_RD = 2'd2,
        ST_LSU_WR = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-master AXI4 arbiter.
// One transaction owns the downstream port from grant until its last response.
module ysyx_24100006_axi_arbiter
    import ysyx_24100006_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ifu_axi_arvalid,
    input  logic [ADDR_W-1:0]   ifu_axi_araddr,
    input  logic [7:0]          ifu_axi_arlen,
    input  logic [2:0]          ifu_axi_arsize,
    output logic                ifu_axi_arready,
    output logic                ifu_axi_rvalid,
    output logic [DATA_W-1:0]   ifu_axi_rdata,
    output logic [1:0]          ifu_axi_rresp,
    output logic                ifu_axi_rlast,
    input  logic                ifu_axi_rready,

    input  logic                lsu_axi_arvalid,
    input  logic [ADDR_W-1:0]   lsu_axi_araddr,
    input  logic [7:0]          lsu_axi_arlen,
    input  logic [2:0]          lsu_axi_arsize,
    output logic                lsu_axi_arready,
    output logic                lsu_axi_rvalid,
    output logic [DATA_W-1:0]   lsu_axi_rdata,
    output logic [1:0]          lsu_axi_rresp,
    output logic                lsu_axi_rlast,
    input  logic                lsu_axi_rready,
    input  logic                lsu_axi_awvalid,
    input  logic [ADDR_W-1:0]   lsu_axi_awaddr,
    input  logic [7:0]          lsu_axi_awlen,
    input  logic [2:0]          lsu_axi_awsize,
    output logic                lsu_axi_awready,
    input  logic                lsu_axi_wvalid,
    input  logic [DATA_W-1:0]   lsu_axi_wdata,
    input  logic [DATA_W/8-1:0] lsu_axi_wstrb,
    input  logic                lsu_axi_wlast,
    output logic                lsu_axi_wready,
    output logic                lsu_axi_bvalid,
    output logic [1:0]          lsu_axi_bresp,
    input  logic                lsu_axi_bready,

    output logic                m_axi_awvalid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    input  logic                m_axi_awready,
    output logic                m_axi_wvalid,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    input  logic                m_axi_wready,
    input  logic                m_axi_bvalid,
    input  logic [1:0]          m_axi_bresp,
    output logic                m_axi_bready,
    output logic                m_axi_arvalid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    input  logic                m_axi_arready,
    input  logic                m_axi_rvalid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    output logic                m_axi_rready,

    output logic [1:0]          m_addr_suffix
);

    arb_state_e state;
    arb_state_e next_state;
    logic [1:0] addr_suffix;
    logic       r_done;
    logic       b_done;

    assign r_done = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign b_done = m_axi_bvalid & m_axi_bready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (lsu_axi_awvalid) begin
                    next_state = ST_LSU_WR;
                end else if (lsu_axi_arvalid) begin
                    next_state = ST_LSU_RD;
                end else if (ifu_axi_arvalid) begin
                    next_state = ST_IFU_RD;
                end
            end
            ST_IFU_RD: if (r_done) next_state = ST_IDLE;
            ST_LSU_RD: if (r_done) next_state = ST_IDLE;
            ST_LSU_WR: if (b_done) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Byte offset of the granted read, kept for sub-word alignment downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_suffix <= 2'b00;
        end else if (state == ST_IDLE && next_state == ST_LSU_RD) begin
            addr_suffix <= lsu_axi_araddr[1:0];
        end else if (state == ST_IDLE && next_state == ST_IFU_RD) begin
            addr_suffix <= ifu_axi_araddr[1:0];
        end
    end

    assign m_addr_suffix = addr_suffix;

    always_comb begin
        ifu_axi_arready = 1'b0;
        ifu_axi_rvalid  = 1'b0;
        ifu_axi_rdata   = '0;
        ifu_axi_rresp   = 2'b00;
        ifu_axi_rlast   = 1'b0;
        lsu_axi_arready = 1'b0;
        lsu_axi_rvalid  = 1'b0;
        lsu_axi_rdata   = '0;
        lsu_axi_rresp   = 2'b00;
        lsu_axi_rlast   = 1'b0;
        lsu_axi_awready = 1'b0;
        lsu_axi_wready  = 1'b0;
        lsu_axi_bvalid  = 1'b0;
        lsu_axi_bresp   = 2'b00;
        m_axi_awvalid   = 1'b0;
        m_axi_awaddr    = '0;
        m_axi_awlen     = 8'd0;
        m_axi_awsize    = 3'd0;
        m_axi_wvalid    = 1'b0;
        m_axi_wdata     = '0;
        m_axi_wstrb     = '0;
        m_axi_wlast     = 1'b0;
        m_axi_bready    = 1'b0;
        m_axi_arvalid   = 1'b0;
        m_axi_araddr    = '0;
        m_axi_arlen     = 8'd0;
        m_axi_arsize    = 3'd0;
        m_axi_rready    = 1'b0;
        unique case (state)
            ST_IFU_RD: begin
                m_axi_arvalid   = ifu_axi_arvalid;
                m_axi_araddr    = ifu_axi_araddr;
                m_axi_arlen     = ifu_axi_arlen;
                m_axi_arsize    = ifu_axi_arsize;
                m_axi_rready    = ifu_axi_rready;
                ifu_axi_arready = m_axi_arready;
                ifu_axi_rvalid  = m_axi_rvalid;
                ifu_axi_rdata   = m_axi_rdata;
                ifu_axi_rresp   = m_axi_rresp;
                ifu_axi_rlast   = m_axi_rlast;
            end
            ST_LSU_RD: begin
                m_axi_arvalid   = lsu_axi_arvalid;
                m_axi_araddr    = lsu_axi_araddr;
                m_axi_arlen     = lsu_axi_arlen;
                m_axi_arsize    = lsu_axi_arsize;
                m_axi_rready    = lsu_axi_rready;
                lsu_axi_arready = m_axi_arready;
                lsu_axi_rvalid  = m_axi_rvalid;
                lsu_axi_rdata   = m_axi_rdata;
                lsu_axi_rresp   = m_axi_rresp;
                lsu_axi_rlast   = m_axi_rlast;
            end
            ST_LSU_WR: begin
                m_axi_awvalid   = lsu_axi_awvalid;
                m_axi_awaddr    = lsu_axi_awaddr;
                m_axi_awlen     = lsu_axi_awlen;
                m_axi_awsize    = lsu_axi_awsize;
                m_axi_wvalid    = lsu_axi_wvalid;
                m_axi_wdata     = lsu_axi_wdata;
                m_axi_wstrb     = lsu_axi_wstrb;
                m_axi_wlast     = lsu_axi_wlast;
                m_axi_bready    = lsu_axi_bready;
                lsu_axi_awready = m_axi_awready;
                lsu_axi_wready  = m_axi_wready;
                lsu_axi_bvalid  = m_axi_bvalid;
                lsu_axi_bresp   = m_axi_bresp;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Randomized and directed bench for the AXI arbiter with an ownership model.
module tb_ysyx_24100006_axi_arbiter;
    import ysyx_24100006_axi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ifu_axi_arvalid, ifu_axi_arready, ifu_axi_rvalid, ifu_axi_rlast;
    logic ifu_axi_rready;
    logic [31:0] ifu_axi_araddr, ifu_axi_rdata;
    logic [7:0] ifu_axi_arlen;
    logic [2:0] ifu_axi_arsize;
    logic [1:0] ifu_axi_rresp;
    logic lsu_axi_arvalid, lsu_axi_arready, lsu_axi_rvalid, lsu_axi_rlast;
    logic lsu_axi_rready;
    logic [31:0] lsu_axi_araddr, lsu_axi_rdata;
    logic [7:0] lsu_axi_arlen;
    logic [2:0] lsu_axi_arsize;
    logic [1:0] lsu_axi_rresp;
    logic lsu_axi_awvalid, lsu_axi_awready, lsu_axi_wvalid, lsu_axi_wlast;
    logic lsu_axi_wready, lsu_axi_bvalid, lsu_axi_bready;
    logic [31:0] lsu_axi_awaddr, lsu_axi_wdata;
    logic [7:0] lsu_axi_awlen;
    logic [2:0] lsu_axi_awsize;
    logic [3:0] lsu_axi_wstrb;
    logic [1:0] lsu_axi_bresp;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wlast, m_axi_wready;
    logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [7:0] m_axi_awlen, m_axi_arlen;
    logic [2:0] m_axi_awsize, m_axi_arsize;
    logic [3:0] m_axi_wstrb;
    logic [1:0] m_axi_bresp, m_axi_rresp, m_addr_suffix;

    int total = 0;
    int bad = 0;
    // Model: who owns the downstream port (0 none, 1 IFU read, 2 LSU read, 3 LSU write)
    int owner = 0;
    logic [1:0] exp_suffix = 2'b00;

    always #5 clk = ~clk;

    ysyx_24100006_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .ifu_axi_arvalid(ifu_axi_arvalid), .ifu_axi_araddr(ifu_axi_araddr),
        .ifu_axi_arlen(ifu_axi_arlen), .ifu_axi_arsize(ifu_axi_arsize),
        .ifu_axi_arready(ifu_axi_arready), .ifu_axi_rvalid(ifu_axi_rvalid),
        .ifu_axi_rdata(ifu_axi_rdata), .ifu_axi_rresp(ifu_axi_rresp),
        .ifu_axi_rlast(ifu_axi_rlast), .ifu_axi_rready(ifu_axi_rready),
        .lsu_axi_arvalid(lsu_axi_arvalid), .lsu_axi_araddr(lsu_axi_araddr),
        .lsu_axi_arlen(lsu_axi_arlen), .lsu_axi_arsize(lsu_axi_arsize),
        .lsu_axi_arready(lsu_axi_arready), .lsu_axi_rvalid(lsu_axi_rvalid),
        .lsu_axi_rdata(lsu_axi_rdata), .lsu_axi_rresp(lsu_axi_rresp),
        .lsu_axi_rlast(lsu_axi_rlast), .lsu_axi_rready(lsu_axi_rready),
        .lsu_axi_awvalid(lsu_axi_awvalid), .lsu_axi_awaddr(lsu_axi_awaddr),
        .lsu_axi_awlen(lsu_axi_awlen), .lsu_axi_awsize(lsu_axi_awsize),
        .lsu_axi_awready(lsu_axi_awready), .lsu_axi_wvalid(lsu_axi_wvalid),
        .lsu_axi_wdata(lsu_axi_wdata), .lsu_axi_wstrb(lsu_axi_wstrb),
        .lsu_axi_wlast(lsu_axi_wlast), .lsu_axi_wready(lsu_axi_wready),
        .lsu_axi_bvalid(lsu_axi_bvalid), .lsu_axi_bresp(lsu_axi_bresp),
        .lsu_axi_bready(lsu_axi_bready),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awready(m_axi_awready), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arready(m_axi_arready), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
        .m_addr_suffix(m_addr_suffix)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        {ifu_axi_arvalid, ifu_axi_araddr, ifu_axi_arlen, ifu_axi_arsize} = '0;
        ifu_axi_rready = 1'b0;
        {lsu_axi_arvalid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize} = '0;
        lsu_axi_rready = 1'b0;
        {lsu_axi_awvalid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize} = '0;
        {lsu_axi_wvalid, lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast} = '0;
        lsu_axi_bready = 1'b0;
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp} = '0;
        {m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = '0;
    endtask

    task automatic rand_inputs();
        reset = ($urandom_range(0, 99) == 0);
        ifu_axi_arvalid = ($urandom_range(0, 2) == 0);
        ifu_axi_araddr = $urandom;
        ifu_axi_arlen = 8'($urandom);
        ifu_axi_arsize = 3'($urandom);
        ifu_axi_rready = 1'($urandom);
        lsu_axi_arvalid = ($urandom_range(0, 2) == 0);
        lsu_axi_araddr = $urandom;
        lsu_axi_arlen = 8'($urandom);
        lsu_axi_arsize = 3'($urandom);
        lsu_axi_rready = 1'($urandom);
        lsu_axi_awvalid = ($urandom_range(0, 3) == 0);
        lsu_axi_awaddr = $urandom;
        lsu_axi_awlen = 8'($urandom);
        lsu_axi_awsize = 3'($urandom);
        lsu_axi_wvalid = 1'($urandom);
        lsu_axi_wdata = $urandom;
        lsu_axi_wstrb = 4'($urandom);
        lsu_axi_wlast = 1'($urandom);
        lsu_axi_bready = 1'($urandom);
        m_axi_awready = 1'($urandom);
        m_axi_wready = 1'($urandom);
        m_axi_bvalid = 1'($urandom);
        m_axi_bresp = 2'($urandom);
        m_axi_arready = 1'($urandom);
        m_axi_rvalid = 1'($urandom);
        m_axi_rdata = $urandom;
        m_axi_rresp = 2'($urandom);
        m_axi_rlast = ($urandom_range(0, 3) == 0);
    endtask

    // Every output is either a pass-through for the owner or zero.
    task automatic check_all();
        logic [63:0] e_mar, e_maw, e_mw, e_ifu, e_lsr, e_lsw;
        logic e_rr, e_br;
        logic [63:0] rsp;
        rsp = {m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
        {e_mar, e_maw, e_mw, e_ifu, e_lsr, e_lsw, e_rr, e_br} = '0;
        if (owner == 1) begin
            e_mar = {ifu_axi_arvalid, ifu_axi_araddr, ifu_axi_arlen, ifu_axi_arsize};
            e_rr = ifu_axi_rready;
            e_ifu = rsp;
        end
        if (owner == 2) begin
            e_mar = {lsu_axi_arvalid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize};
            e_rr = lsu_axi_rready;
            e_lsr = rsp;
        end
        if (owner == 3) begin
            e_maw = {lsu_axi_awvalid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize};
            e_mw = {lsu_axi_wvalid, lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast};
            e_br = lsu_axi_bready;
            e_lsw = {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp};
        end
        chk("m_ar", {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize}, e_mar);
        chk("m_rready", m_axi_rready, e_rr);
        chk("m_aw", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize}, e_maw);
        chk("m_w", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast}, e_mw);
        chk("m_bready", m_axi_bready, e_br);
        chk("ifu_side", {ifu_axi_arready, ifu_axi_rvalid, ifu_axi_rdata,
                         ifu_axi_rresp, ifu_axi_rlast}, e_ifu);
        chk("lsu_rd_side", {lsu_axi_arready, lsu_axi_rvalid, lsu_axi_rdata,
                            lsu_axi_rresp, lsu_axi_rlast}, e_lsr);
        chk("lsu_wr_side", {lsu_axi_awready, lsu_axi_wready, lsu_axi_bvalid,
                            lsu_axi_bresp}, e_lsw);
        chk("suffix", m_addr_suffix, exp_suffix);
    endtask

    task automatic model_edge();
        if (reset) begin
            owner = 0;
            exp_suffix = 2'b00;
        end else if (owner == 0) begin
            if (lsu_axi_awvalid) begin
                owner = 3;
            end else if (lsu_axi_arvalid) begin
                owner = 2;
                exp_suffix = lsu_axi_araddr[1:0];
            end else if (ifu_axi_arvalid) begin
                owner = 1;
                exp_suffix = ifu_axi_araddr[1:0];
            end
        end else if (owner == 1) begin
            if (m_axi_rvalid && ifu_axi_rready && m_axi_rlast) owner = 0;
        end else if (owner == 2) begin
            if (m_axi_rvalid && lsu_axi_rready && m_axi_rlast) owner = 0;
        end else begin
            if (m_axi_bvalid && lsu_axi_bready) owner = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int beats;
        clear_inputs();
        reset = 1'b1;
        owner = 3;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_m_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_suffix", m_addr_suffix, 2'b00);

        // IFU single read
        ifu_axi_arvalid = 1'b1;
        ifu_axi_araddr = 32'h8000_0004;
        #1;
        chk("idle_ifu_arready", ifu_axi_arready, 1'b0);
        step();
        m_axi_arready = 1'b1;
        #1;
        chk("ifu_arready", ifu_axi_arready, 1'b1);
        step();
        ifu_axi_arvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata = 32'h1234_5678;
        m_axi_rlast = 1'b1;
        ifu_axi_rready = 1'b1;
        #1;
        chk("ifu_rdata", ifu_axi_rdata, 32'h1234_5678);
        chk("ifu_suffix", m_addr_suffix, 2'b00);
        step();
        chk("ifu_done_idle", ifu_axi_rvalid, 1'b0);
        clear_inputs();

        // LSU read beats a simultaneous IFU read
        ifu_axi_arvalid = 1'b1;
        ifu_axi_araddr = 32'h8000_0008;
        lsu_axi_arvalid = 1'b1;
        lsu_axi_araddr = 32'ha000_03fb;
        step();
        m_axi_arready = 1'b1;
        #1;
        chk("lsu_first_suffix", m_addr_suffix, 2'd3);
        chk("lsu_first_arready", lsu_axi_arready, 1'b1);
        chk("ifu_wait_arready", ifu_axi_arready, 1'b0);
        step();
        lsu_axi_arvalid = 1'b0;
        m_axi_arready = 1'b0;
        {m_axi_rvalid, m_axi_rlast, lsu_axi_rready} = 3'b111;
        m_axi_rresp = RESP_SLVERR;
        #1;
        chk("lsu_rresp_err", lsu_axi_rresp, RESP_SLVERR);
        step();
        {m_axi_rvalid, m_axi_rlast, lsu_axi_rready} = 3'b000;
        m_axi_rresp = RESP_OKAY;
        step();
        m_axi_arready = 1'b1;
        #1;
        chk("ifu_later_arready", ifu_axi_arready, 1'b1);
        step();
        clear_inputs();

        // IFU 4-beat burst, LSU request arrives mid-burst
        {m_axi_rvalid, m_axi_rlast, ifu_axi_rready} = 3'b000;
        step();
        ifu_axi_arvalid = 1'b1;
        ifu_axi_arlen = 8'd3;
        step();
        ifu_axi_arvalid = 1'b0;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            {m_axi_rvalid, ifu_axi_rready} = 2'b11;
            m_axi_rlast = (i == 3);
            m_axi_rdata = 32'h100 + i;
            lsu_axi_arvalid = (i >= 1);
            #1;
            if (ifu_axi_rvalid) beats++;
            chk("burst_lsu_wait", lsu_axi_arready | m_axi_araddr[0], 1'b0);
            step();
        end
        chk("burst_beats", beats, 4);
        clear_inputs();
        lsu_axi_arvalid = 1'b1;
        step();
        m_axi_arready = 1'b1;
        #1;
        chk("after_burst_lsu", lsu_axi_arready, 1'b1);
        clear_inputs();
        {m_axi_rvalid, m_axi_rlast, lsu_axi_rready} = 3'b111;
        step();
        clear_inputs();

        // LSU aw+ar together: write first, reset after aw handshake
        lsu_axi_awvalid = 1'b1;
        lsu_axi_arvalid = 1'b1;
        lsu_axi_wvalid = 1'b1;
        lsu_axi_wdata = 32'hdead_beef;
        lsu_axi_wstrb = 4'hf;
        lsu_axi_wlast = 1'b1;
        step();
        m_axi_awready = 1'b1;
        m_axi_wready = 1'b1;
        #1;
        chk("wr_wdata", m_axi_wdata, 32'hdead_beef);
        chk("wr_ar_blocked", m_axi_arvalid, 1'b0);
        step();
        {lsu_axi_awvalid, lsu_axi_wvalid, m_axi_awready, m_axi_wready} = '0;
        {m_axi_bvalid, lsu_axi_bready} = 2'b11;
        #1;
        chk("wr_bvalid", lsu_axi_bvalid, 1'b1);
        step();
        {m_axi_bvalid, lsu_axi_bready} = 2'b00;
        step();
        m_axi_arready = 1'b1;
        #1;
        chk("rd_after_wr", lsu_axi_arready, 1'b1);
        clear_inputs();
        {m_axi_rvalid, m_axi_rlast, lsu_axi_rready} = 3'b111;
        step();
        clear_inputs();
        lsu_axi_awvalid = 1'b1;
        step();
        m_axi_awready = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        {m_axi_bvalid, lsu_axi_bready} = 2'b11;
        #1;
        chk("rst_late_bvalid", lsu_axi_bvalid, 1'b0);
        chk("rst_m_bready", m_axi_bready, 1'b0);
        step();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
